// File: rtl/i2s_rx_frame_ctrl.sv
// Stereo I2S receive sequencer: follows WS, enables the left/right receivers
// for one word each and hands the collected {left, right} pair to the mixer.
module i2s_rx_frame_ctrl #(
  parameter int BITS_PRECISION = 10
) (
  input  logic                          sck,
  input  logic                          rst,
  input  logic                          run,
  input  logic                          ws,
  output logic                          en_l,
  output logic                          en_r,
  input  logic [BITS_PRECISION-1:0]     data_l,
  input  logic                          dv_l,
  input  logic [BITS_PRECISION-1:0]     data_r,
  input  logic                          dv_r,
  output logic [2*BITS_PRECISION-1:0]   frame,
  output logic                          frame_valid,
  input  logic                          frame_ready,
  output logic                          short_err,
  output logic                          overflow,
  input  logic                          err_clr
);

  localparam int CW = (BITS_PRECISION > 1) ? $clog2(BITS_PRECISION) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BITS_PRECISION - 1);

  typedef enum logic [2:0] {SYNC, RX_L, WAIT_R, RX_R, WAIT_L} state_t;

  state_t                      state;
  logic                        ws_q;
  logic [CW-1:0]               cnt;
  logic [BITS_PRECISION-1:0]   l_lat;
  logic                        pend_l;
  logic                        pend_r;
  logic                        l_have;

  logic ws_edge, fall, rise;
  logic cap_l, cap_r, pair_done, ovf_set, short_set;

  assign ws_edge = ws ^ ws_q;
  assign fall    = ws_edge & ~ws;
  assign rise    = ws_edge & ws;

  // A pair only completes when its left word was actually captured, so a
  // discarded or truncated left slot can never produce a frame.
  always_comb begin
    cap_l     = run & pend_l & dv_l;
    cap_r     = run & pend_r & dv_r;
    pair_done = cap_r & l_have;
    ovf_set   = pair_done & frame_valid & ~frame_ready;
    short_set = 1'b0;
    unique case (state)
      RX_L, RX_R: short_set = ws_edge;
      WAIT_R:     short_set = fall;
      WAIT_L:     short_set = rise;
      default:    short_set = 1'b0;
    endcase
    short_set = short_set & run;
  end

  // NOTE: all state uses non-blocking assignments; later assignments in this
  // block intentionally override earlier ones (run=0 and discards win).
  always_ff @(posedge sck or posedge rst) begin
    if (rst) begin
      state  <= SYNC;
      ws_q   <= 1'b0;
      cnt    <= '0;
      en_l   <= 1'b0;
      en_r   <= 1'b0;
      // NOTE: the left-word holding register is reset too, so a frame can
      // never expose stale data from before reset.
      l_lat  <= '0;
      pend_l <= 1'b0;
      pend_r <= 1'b0;
      l_have <= 1'b0;
    end else begin
      ws_q <= ws;

      if (cap_l) begin
        l_lat  <= data_l;
        l_have <= 1'b1;
        pend_l <= 1'b0;
      end
      if (cap_r) begin
        pend_r <= 1'b0;
        l_have <= 1'b0;
      end

      if (!run) begin
        state  <= SYNC;
        en_l   <= 1'b0;
        en_r   <= 1'b0;
        pend_l <= 1'b0;
        pend_r <= 1'b0;
        l_have <= 1'b0;
      end else begin
        unique case (state)
          SYNC: begin
            if (fall) begin
              state <= RX_L; en_l <= 1'b1; cnt <= CNT_MAX; pend_l <= 1'b0;
            end
          end
          RX_L, RX_R: begin
            if (ws_edge) begin
              // Short slot: abandon the partial pair, start the new channel now.
              pend_l <= 1'b0; pend_r <= 1'b0; l_have <= 1'b0;
              cnt    <= CNT_MAX;
              en_l   <= ~ws;
              en_r   <= ws;
              state  <= ws ? RX_R : RX_L;
            end else if (cnt == '0) begin
              en_l <= 1'b0;
              en_r <= 1'b0;
              if (state == RX_L) begin
                pend_l <= 1'b1; state <= WAIT_R;
              end else begin
                pend_r <= 1'b1; state <= WAIT_L;
              end
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          WAIT_R: begin
            if (rise) begin
              state <= RX_R; en_r <= 1'b1; cnt <= CNT_MAX;
            end else if (fall) begin
              pend_l <= 1'b0; pend_r <= 1'b0; l_have <= 1'b0;
              state <= RX_L; en_l <= 1'b1; cnt <= CNT_MAX;
            end
          end
          WAIT_L: begin
            if (fall) begin
              state <= RX_L; en_l <= 1'b1; cnt <= CNT_MAX; pend_l <= 1'b0;
            end else if (rise) begin
              pend_l <= 1'b0; pend_r <= 1'b0; l_have <= 1'b0;
              state <= RX_R; en_r <= 1'b1; cnt <= CNT_MAX;
            end
          end
          default: begin
            state <= SYNC; en_l <= 1'b0; en_r <= 1'b0;
          end
        endcase
      end
    end
  end

  // Output handshake and sticky flags; a set in the same cycle as err_clr wins.
  always_ff @(posedge sck or posedge rst) begin
    if (rst) begin
      frame       <= '0;
      frame_valid <= 1'b0;
      short_err   <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (pair_done && !ovf_set) begin
        frame       <= {l_lat, data_r};
        frame_valid <= 1'b1;
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
      short_err <= short_set | (short_err & ~err_clr);
      overflow  <= ovf_set   | (overflow  & ~err_clr);
    end
  end

endmodule

// File: tb/tb_i2s_rx_frame_ctrl.sv
// Directed bench for i2s_rx_frame_ctrl: drives WS slots of 20 sck with
// receiver dv pulses and checks enables, frames, handshake and error flags.
module tb_i2s_rx_frame_ctrl;

  localparam int B = 10;

  logic           sck = 1'b0;
  logic           rst;
  logic           run;
  logic           ws;
  logic           en_l, en_r;
  logic [B-1:0]   data_l, data_r;
  logic           dv_l, dv_r;
  logic [2*B-1:0] frame;
  logic           frame_valid;
  logic           frame_ready;
  logic           short_err;
  logic           overflow;
  logic           err_clr;

  int tests_run = 0;
  int tests_failed = 0;

  logic [2*B-1:0] got_q[$];
  logic [31:0]    em, om, fm;

  i2s_rx_frame_ctrl #(.BITS_PRECISION(B)) dut (
    .sck         (sck),
    .rst         (rst),
    .run         (run),
    .ws          (ws),
    .en_l        (en_l),
    .en_r        (en_r),
    .data_l      (data_l),
    .dv_l        (dv_l),
    .data_r      (data_r),
    .dv_r        (dv_r),
    .frame       (frame),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .short_err   (short_err),
    .overflow    (overflow),
    .err_clr     (err_clr)
  );

  always #5 sck = ~sck;

  // Record every accepted frame (valid & ready seen by the next posedge).
  always @(negedge sck) begin
    if (!rst && frame_valid && frame_ready) got_q.push_back(frame);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sck);
    #1;
  endtask

  // One WS slot of len cycles; dv for the matching receiver pulses at dv_at.
  task automatic slot(input logic w, input logic [B-1:0] d, input int dv_at, input int len,
                      output logic [31:0] en_mask, output logic [31:0] oth_mask,
                      output logic [31:0] fv_mask);
    en_mask = '0; oth_mask = '0; fv_mask = '0;
    ws = w;
    for (int i = 0; i < len; i++) begin
      if (!w) begin data_l = d; dv_l = (i == dv_at); end
      else    begin data_r = d; dv_r = (i == dv_at); end
      tick();
      en_mask[i]  = w ? en_r : en_l;
      oth_mask[i] = w ? en_l : en_r;
      fv_mask[i]  = frame_valid;
    end
    dv_l = 1'b0;
    dv_r = 1'b0;
  endtask

  task automatic pair(input logic [B-1:0] l, input logic [B-1:0] r);
    slot(1'b0, l, 12, 20, em, om, fm);
    slot(1'b1, r, 12, 20, em, om, fm);
  endtask

  task automatic expect_frame(input string tag, input logic [2*B-1:0] e);
    logic [31:0] v;
    v = 'x;
    if (got_q.size() != 0) v = 32'(got_q.pop_front());
    check(tag, v, 32'(e));
  endtask

  initial begin
    rst = 1'b1; run = 1'b1; ws = 1'b0; data_l = '0; data_r = '0;
    dv_l = 1'b0; dv_r = 1'b0; frame_ready = 1'b1; err_clr = 1'b0;
    tick(); tick();
    check("reset_outputs", 32'({en_l, en_r, frame_valid, short_err, overflow, frame}), 32'd0);
    rst = 1'b0;

    // 1: basic L=0x2AA, R=0x155 after a leading right slot seen in SYNC
    slot(1'b1, 10'h000, 99, 20, em, om, fm);
    check("sync_no_enable", em | om, 32'd0);
    slot(1'b0, 10'h2AA, 12, 20, em, om, fm);
    check("t1_en_l_window", em, 32'h0000_03FF);
    slot(1'b1, 10'h155, 12, 20, em, om, fm);
    check("t1_en_r_window", em, 32'h0000_03FF);
    check("t1_valid_timing", fm, 32'h0000_1000);
    expect_frame("t1_frame", 20'hAA955);
    check("t1_no_flags", 32'({short_err, overflow}), 32'd0);

    // 2: ws rises 4 cycles into the left word
    slot(1'b0, 10'h3C3, 12, 4, em, om, fm);
    check("t2_en_l_partial", em, 32'h0000_000F);
    slot(1'b1, 10'h0F0, 12, 20, em, om, fm);
    check("t2_en_r_window", em, 32'h0000_03FF);
    check("t2_en_l_dropped", om, 32'd0);
    check("t2_short_err", 32'(short_err), 32'd1);
    check("t2_no_frame", 32'(got_q.size()), 32'd0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("t2_short_clr", 32'(short_err), 32'd0);
    pair(10'h111, 10'h222);
    expect_frame("t2_recover", {10'h111, 10'h222});

    // 3: consumer stalls across two pairs
    frame_ready = 1'b0;
    pair(10'h001, 10'h3FF);
    check("t3_first_valid", 32'({frame_valid, frame}), 32'({1'b1, 10'h001, 10'h3FF}));
    check("t3_no_ovf_yet", 32'(overflow), 32'd0);
    pair(10'h155, 10'h2AA);
    check("t3_frame_held", 32'({frame_valid, frame}), 32'({1'b1, 10'h001, 10'h3FF}));
    check("t3_overflow", 32'(overflow), 32'd1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("t3_ovf_clr", 32'(overflow), 32'd0);
    frame_ready = 1'b1; tick();
    expect_frame("t3_drain", {10'h001, 10'h3FF});
    check("t3_valid_clr", 32'(frame_valid), 32'd0);

    // 4: eight back-to-back frames with an always-ready consumer
    for (int i = 0; i < 8; i++) begin
      logic [B-1:0] l, r;
      l = B'(i * 37 + 5);
      r = ~B'(i * 53);
      pair(l, r);
      expect_frame($sformatf("t4_frame%0d", i), {l, r});
    end
    check("t4_no_overflow", 32'(overflow), 32'd0);

    // run=0 mid left word returns to SYNC
    slot(1'b0, 10'h0AA, 99, 3, em, om, fm);
    run = 1'b0; tick();
    check("run0_en_l", 32'(en_l), 32'd0);
    run = 1'b1;
    slot(1'b1, 10'h000, 12, 20, em, om, fm);
    check("run0_sync_idle", em | om, 32'd0);
    pair(10'h2F0, 10'h10F);
    expect_frame("run0_recover", {10'h2F0, 10'h10F});

    // 5: async reset during the right word
    slot(1'b0, 10'h123, 12, 20, em, om, fm);
    slot(1'b1, 10'h321, 99, 5, em, om, fm);
    check("t5_en_r_before", 32'(en_r), 32'd1);
    #2 rst = 1'b1;
    #1 check("t5_en_r_async", 32'({en_l, en_r}), 32'd0);
    tick(); tick();
    rst = 1'b0;
    slot(1'b1, 10'h321, 12, 15, em, om, fm);
    check("t5_idle_after", em | om, 32'd0);
    check("t5_no_frame", 32'(got_q.size()), 32'd0);
    pair(10'h246, 10'h135);
    expect_frame("t5_recover", {10'h246, 10'h135});

    // 6: reset released with ws already high
    ws = 1'b1; rst = 1'b1; tick(); rst = 1'b0;
    slot(1'b1, 10'h0FF, 12, 20, em, om, fm);
    check("t6_sync_hold", em | om, 32'd0);
    check("t6_no_frame", 32'(got_q.size()), 32'd0);
    slot(1'b0, 10'h3A5, 12, 20, em, om, fm);
    check("t6_first_en_l", em, 32'h0000_03FF);
    slot(1'b1, 10'h05A, 12, 20, em, om, fm);
    expect_frame("t6_frame", {10'h3A5, 10'h05A});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
